// File: rtl/i2c_sim_bus.sv
// i2c_sim_bus: simulation I2C fabric. For each bus, the controller's open-drain
// drive is wired-AND'ed with a built-in memory target. The result is returned
// to the controller as the bus lines.
// Ports: clk_i/rst_i (sync, active-high). Controller drive comes in on
// scl_o/scl_oe_i/sda_o/sda_oe_i. Resolved lines go out on scl_i/sda_i.
// busy_o is high between START and STOP.
module i2c_sim_bus #(
    parameter int                NumBus         = 2,
    parameter logic [6:0]        TargetAddrBase = 7'h50,
    parameter int                MemDepth       = 16,
    parameter logic [NumBus-1:0] TargetEn       = {NumBus{1'b1}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumBus-1:0] scl_o,
    input  logic [NumBus-1:0] scl_oe_i,
    input  logic [NumBus-1:0] sda_o,
    input  logic [NumBus-1:0] sda_oe_i,
    output logic [NumBus-1:0] scl_i,
    output logic [NumBus-1:0] sda_i,
    output logic [NumBus-1:0] busy_o
);
    localparam int PW = (MemDepth > 1) ? $clog2(MemDepth) : 1;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_ADDR     = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK = 4'd2;
    localparam logic [3:0] ST_PTR      = 4'd3;
    localparam logic [3:0] ST_PTR_ACK  = 4'd4;
    localparam logic [3:0] ST_WDATA    = 4'd5;
    localparam logic [3:0] ST_WACK     = 4'd6;
    localparam logic [3:0] ST_RDATA    = 4'd7;
    localparam logic [3:0] ST_RACK     = 4'd8;
    localparam logic [3:0] ST_WAIT     = 4'd9;

    for (genvar g = 0; g < NumBus; g++) begin : g_bus
        localparam logic [6:0] Addr = TargetAddrBase + 7'(g);

        logic [7:0]    mem [MemDepth];
        logic [3:0]    state;
        logic [3:0]    bit_cnt;
        logic [7:0]    rx;
        logic [7:0]    tx;
        logic [PW-1:0] ptr;
        logic [PW-1:0] ptr_inc;
        logic          rw;
        logic          pull;
        logic          busy;
        logic          scl_q;
        logic          sda_q;
        logic          scl_r;
        logic          sda_r;
        logic          scl_rise;
        logic          scl_fall;
        logic          start_det;
        logic          stop_det;
        logic [7:0]    rd_cur;
        logic [7:0]    rd_next;

        assign scl_r = scl_oe_i[g] ? scl_o[g] : 1'b1;
        assign sda_r = (sda_oe_i[g] ? sda_o[g] : 1'b1) & ~pull;

        assign scl_i[g]  = scl_r;
        assign sda_i[g]  = sda_r;
        assign busy_o[g] = busy;

        // START/STOP need SCL high in both samples, so a simultaneous
        // SCL+SDA edge is seen only as an SCL edge.
        assign scl_rise  = scl_r & ~scl_q;
        assign scl_fall  = ~scl_r & scl_q;
        assign start_det = scl_r & scl_q & sda_q & ~sda_r;
        assign stop_det  = scl_r & scl_q & ~sda_q & sda_r;

        assign ptr_inc = ptr + 1'b1;
        assign rd_cur  = mem[ptr];
        assign rd_next = mem[ptr_inc];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state   <= ST_IDLE;
                bit_cnt <= 4'd0;
                rx      <= 8'd0;
                tx      <= 8'd0;
                ptr     <= '0;
                rw      <= 1'b0;
                pull    <= 1'b0;
                busy    <= 1'b0;
                scl_q   <= 1'b1;
                sda_q   <= 1'b1;
                for (int k = 0; k < MemDepth; k++) begin
                    mem[k] <= 8'(k);
                end
            end else begin
                scl_q <= scl_r;
                sda_q <= sda_r;
                if (start_det) begin
                    state   <= ST_ADDR;
                    bit_cnt <= 4'd0;
                    pull    <= 1'b0;
                    busy    <= 1'b1;
                end else if (stop_det) begin
                    state   <= ST_IDLE;
                    bit_cnt <= 4'd0;
                    pull    <= 1'b0;
                    busy    <= 1'b0;
                end else if (scl_rise) begin
                    rx      <= {rx[6:0], sda_r};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (scl_fall) begin
                    // All target SDA changes happen here, just after SCL falls.
                    unique case (state)
                        ST_ADDR: begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd0;
                                if (rx[7:1] == Addr && TargetEn[g]) begin
                                    state <= ST_ADDR_ACK;
                                    rw    <= rx[0];
                                    pull  <= 1'b1;
                                end else begin
                                    state <= ST_WAIT;
                                end
                            end
                        end
                        ST_ADDR_ACK: begin
                            bit_cnt <= 4'd0;
                            if (rw) begin
                                state <= ST_RDATA;
                                tx    <= {rd_cur[6:0], 1'b0};
                                pull  <= ~rd_cur[7];
                            end else begin
                                state <= ST_PTR;
                                pull  <= 1'b0;
                            end
                        end
                        ST_PTR: begin
                            if (bit_cnt == 4'd8) begin
                                ptr     <= rx[PW-1:0];
                                state   <= ST_PTR_ACK;
                                pull    <= 1'b1;
                                bit_cnt <= 4'd0;
                            end
                        end
                        ST_PTR_ACK, ST_WACK: begin
                            state   <= ST_WDATA;
                            pull    <= 1'b0;
                            bit_cnt <= 4'd0;
                        end
                        ST_WDATA: begin
                            if (bit_cnt == 4'd8) begin
                                mem[ptr] <= rx;
                                ptr      <= ptr_inc;
                                state    <= ST_WACK;
                                pull     <= 1'b1;
                                bit_cnt  <= 4'd0;
                            end
                        end
                        ST_RDATA: begin
                            if (bit_cnt == 4'd8) begin
                                state   <= ST_RACK;
                                pull    <= 1'b0;
                                bit_cnt <= 4'd0;
                            end else begin
                                pull <= ~tx[7];
                                tx   <= {tx[6:0], 1'b0};
                            end
                        end
                        ST_RACK: begin
                            // rx[0] holds SDA from the 9th rise: 0 = ACK.
                            bit_cnt <= 4'd0;
                            if (!rx[0]) begin
                                ptr   <= ptr_inc;
                                state <= ST_RDATA;
                                tx    <= {rd_next[6:0], 1'b0};
                                pull  <= ~rd_next[7];
                            end else begin
                                state <= ST_WAIT;
                                pull  <= 1'b0;
                            end
                        end
                        ST_IDLE, ST_WAIT: begin
                        end
                        default: begin
                            state <= ST_IDLE;
                            pull  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_sim_bus.sv
// tb_i2c_sim_bus: directed bench for i2c_sim_bus with a byte-level target
// model and a per-cycle line/busy checker.
module tb_i2c_sim_bus;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] scl_o;
    logic [1:0] scl_oe;
    logic [1:0] sda_o;
    logic [1:0] sda_oe;
    logic [1:0] scl_i;
    logic [1:0] sda_i;
    logic [1:0] busy;

    always #5 clk = ~clk;

    i2c_sim_bus dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .scl_o    (scl_o),
        .scl_oe_i (scl_oe),
        .sda_o    (sda_o),
        .sda_oe_i (sda_oe),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .busy_o   (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endfunction

    function automatic void check1(string name, logic act, logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b", name, act, exp);
    endfunction

    // Byte-level target model: 0 idle, 1 expect address, 2 expect pointer,
    // 3 write data, 4 read data, 5 not addressed.
    logic [7:0] m_mem [2][16];
    int         m_ptr [2];
    int         m_st  [2];

    function automatic void m_reset();
        for (int b = 0; b < 2; b++) begin
            m_ptr[b] = 0;
            m_st[b]  = 0;
            for (int k = 0; k < 16; k++) m_mem[b][k] = 8'(k);
        end
    endfunction

    function automatic bit m_wr(int b, logic [7:0] d);
        bit ack = 1'b0;
        case (m_st[b])
            1: begin
                if (int'(d[7:1]) == 'h50 + b) begin
                    m_st[b] = d[0] ? 4 : 2;
                    ack = 1'b1;
                end else begin
                    m_st[b] = 5;
                end
            end
            2: begin
                m_ptr[b] = int'(d) % 16;
                m_st[b]  = 3;
                ack = 1'b1;
            end
            3: begin
                m_mem[b][m_ptr[b]] = d;
                m_ptr[b] = (m_ptr[b] + 1) % 16;
                ack = 1'b1;
            end
            default: ack = 1'b0;
        endcase
        return ack;
    endfunction

    function automatic void m_rack(int b, bit ack);
        if (ack) m_ptr[b] = (m_ptr[b] + 1) % 16;
        else m_st[b] = 5;
    endfunction

    logic [1:0] chk_sda  = 2'b00;
    logic [1:0] exp_sda  = 2'b11;
    logic [1:0] chk_busy = 2'b00;
    logic [1:0] exp_busy = 2'b00;

    always @(negedge clk) begin
        for (int b = 0; b < 2; b++) begin
            check1("scl_line", scl_i[b], scl_oe[b] ? scl_o[b] : 1'b1);
            if (chk_sda[b]) check1("sda_line", sda_i[b], exp_sda[b]);
            if (chk_busy[b]) check1("busy_line", busy[b], exp_busy[b]);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One SCL pulse; SCL is low on entry and on exit.
    task automatic clk_bit(input int b, input logic drv, input logic exp_line,
                           output logic got);
        sda_oe[b] = ~drv;
        tick(4);
        scl_oe[b] = 1'b0;
        tick(1);
        exp_sda[b] = exp_line;
        chk_sda[b] = 1'b1;
        got = sda_i[b];
        tick(3);
        chk_sda[b] = 1'b0;
        scl_oe[b] = 1'b1;
    endtask

    task automatic start(input int b);
        sda_oe[b] = 1'b0;
        tick(4);
        scl_oe[b] = 1'b0;
        tick(4);
        chk_busy[b] = 1'b0;
        sda_oe[b] = 1'b1;
        tick(4);
        exp_busy[b] = 1'b1;
        chk_busy[b] = 1'b1;
        scl_oe[b] = 1'b1;
        tick(4);
        m_st[b] = 1;
    endtask

    task automatic stop(input int b);
        sda_oe[b] = 1'b1;
        tick(4);
        scl_oe[b] = 1'b0;
        tick(4);
        chk_busy[b] = 1'b0;
        sda_oe[b] = 1'b0;
        tick(4);
        exp_busy[b] = 1'b0;
        chk_busy[b] = 1'b1;
        m_st[b] = 0;
    endtask

    task automatic wr_byte(input int b, input logic [7:0] d, output logic ack);
        logic g;
        bit   e;
        e = m_wr(b, d);
        for (int i = 7; i >= 0; i--) clk_bit(b, d[i], d[i], g);
        clk_bit(b, 1'b1, ~e, g);
        ack = ~g;
    endtask

    task automatic rd_byte(input int b, input logic ack, output logic [7:0] d);
        logic [7:0] e;
        logic       g;
        e = m_mem[b][m_ptr[b]];
        for (int i = 7; i >= 0; i--) begin
            clk_bit(b, 1'b1, e[i], g);
            d[i] = g;
        end
        clk_bit(b, ~ack, ~ack, g);
        m_rack(b, ack);
    endtask

    task automatic set_ptr_read(input int b, input logic [7:0] p);
        logic a;
        start(b);
        wr_byte(b, 8'hA0 + 8'(2 * b), a);
        wr_byte(b, p, a);
        start(b);
        wr_byte(b, 8'hA1 + 8'(2 * b), a);
        check1("rd_addr_ack", a, 1'b1);
    endtask

    initial begin
        #3000000;
        n_chk++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        logic       a;
        logic       g;
        logic [7:0] d;

        rst    = 1'b1;
        scl_o  = 2'b00;
        sda_o  = 2'b00;
        scl_oe = 2'b00;
        sda_oe = 2'b00;
        m_reset();
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_lines", {4'd0, scl_i, sda_i}, 8'h0F);
        check("reset_busy", {6'd0, busy}, 8'h00);
        chk_busy = 2'b11;

        // Write A5, 5A at pointer 3.
        start(0);
        check1("busy_on", busy[0], 1'b1);
        wr_byte(0, 8'hA0, a); check1("w_addr_ack", a, 1'b1);
        wr_byte(0, 8'h03, a); check1("w_ptr_ack", a, 1'b1);
        wr_byte(0, 8'hA5, a); check1("w_d0_ack", a, 1'b1);
        wr_byte(0, 8'h5A, a); check1("w_d1_ack", a, 1'b1);
        stop(0);
        check1("busy_off", busy[0], 1'b0);

        // Address miss: no ACK, no pull on later bytes.
        start(0);
        wr_byte(0, 8'hA4, a); check1("miss_ack", a, 1'b0);
        wr_byte(0, 8'h00, a); check1("miss_d_ack", a, 1'b0);
        stop(0);

        // Read back with ACK then NACK, then SDA stays released.
        set_ptr_read(0, 8'h03);
        rd_byte(0, 1'b1, d); check("rd_b0", d, 8'hA5);
        rd_byte(0, 1'b0, d); check("rd_b1", d, 8'h5A);
        for (int i = 0; i < 9; i++) clk_bit(0, 1'b1, 1'b1, g);
        check1("nack_release", sda_i[0], 1'b1);
        stop(0);

        // Pointer wrap.
        start(0);
        wr_byte(0, 8'hA0, a);
        wr_byte(0, 8'h1F, a);
        wr_byte(0, 8'h11, a);
        wr_byte(0, 8'h22, a); check1("wrap_w_ack", a, 1'b1);
        stop(0);
        set_ptr_read(0, 8'h0E);
        rd_byte(0, 1'b1, d); check("wrap_r0", d, 8'h0E);
        rd_byte(0, 1'b1, d); check("wrap_r1", d, 8'h11);
        rd_byte(0, 1'b0, d); check("wrap_r2", d, 8'h22);
        stop(0);

        // Reset while the target is driving a 0 bit.
        set_ptr_read(0, 8'h03);
        clk_bit(0, 1'b1, 1'b1, g);
        tick(3);
        check1("pre_rst_pull", sda_i[0], 1'b0);
        chk_busy = 2'b00;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check1("rst_release", sda_i[0], 1'b1);
        check1("rst_busy", busy[0], 1'b0);
        m_reset();
        exp_busy = 2'b00;
        chk_busy = 2'b11;
        scl_oe[0] = 1'b0;
        tick(4);
        set_ptr_read(0, 8'h03);
        rd_byte(0, 1'b0, d); check("rst_mem3", d, 8'h03);
        stop(0);

        // Concurrent transfers on both buses.
        fork
            begin : f_bus0
                logic a0;
                start(0);
                wr_byte(0, 8'hA0, a0); check1("mb0_addr_ack", a0, 1'b1);
                wr_byte(0, 8'h05, a0);
                wr_byte(0, 8'h77, a0); check1("mb0_d_ack", a0, 1'b1);
                stop(0);
            end
            begin : f_bus1
                logic a1;
                start(1);
                wr_byte(1, 8'hA2, a1); check1("mb1_addr_ack", a1, 1'b1);
                wr_byte(1, 8'h06, a1);
                wr_byte(1, 8'h88, a1); check1("mb1_d_ack", a1, 1'b1);
                stop(1);
            end
        join
        start(1);
        wr_byte(1, 8'hA0, a); check1("mb1_foreign_nack", a, 1'b0);
        stop(1);
        set_ptr_read(1, 8'h05);
        rd_byte(1, 1'b1, d); check("mb1_r5", d, 8'h05);
        rd_byte(1, 1'b0, d); check("mb1_r6", d, 8'h88);
        stop(1);
        set_ptr_read(0, 8'h05);
        rd_byte(0, 1'b0, d); check("mb0_r5", d, 8'h77);
        stop(0);

        // SCL override on bus 1 only.
        scl_o[1]  = 1'b0;
        scl_oe[1] = 1'b1;
        scl_o[0]  = 1'b1;
        scl_oe[0] = 1'b1;
        tick(2);
        check1("scl1_forced", scl_i[1], 1'b0);
        check1("scl0_free", scl_i[0], 1'b1);
        scl_oe = 2'b00;
        scl_o  = 2'b00;
        tick(4);
        check("idle_lines", {4'd0, scl_i, sda_i}, 8'h0F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/i2c_sim_bus.md
# i2c_sim_bus

Simulation-only multi-bus I2C fabric for the Verilator top level, replacing the "tie released lines high" arrangement. For each of `NumBus` buses it resolves the controller's open-drain drive together with a built-in memory-style I2C target into the `scl_i`/`sda_i` values fed back to the controller. Each bus gets its own target at a distinct 7-bit address, so I2C driver software can be exercised end to end without external models.

## Interface
- `NumBus`, default 2: number of independent I2C buses (1..8).
- `TargetAddrBase`, default 7'h50: bus `i` target responds at address `TargetAddrBase + i`.
- `MemDepth`, default 16: bytes of target memory per bus; power of two, 2..256.
- `TargetEn`, default `{NumBus{1'b1}}`: per-bus enable. A disabled target never drives SDA.

Ports:
- `clk_i`  in  1  system clock, same clock as the system core.
- `rst_i`  in  1  reset; synchronous, active-high.
- `scl_o`  in  NumBus  controller SCL output value.
- `scl_oe_i`  in  NumBus  controller SCL output enable.
- `sda_o`  in  NumBus  controller SDA output value.
- `sda_oe_i`  in  NumBus  controller SDA output enable.
- `scl_i`  out  NumBus  resolved SCL, returned to the controller.
- `sda_i`  out  NumBus  resolved SDA, returned to the controller.
- `busy_o`  out  NumBus  bus between START and STOP.

## Operation
- Line resolution is combinational wired-AND.
  - `scl_i[i] = scl_oe_i[i] ? scl_o[i] : 1`. The target never stretches the clock.
  - `sda_i[i] = (sda_oe_i[i] ? sda_o[i] : 1) & ~tgt_pull[i]`.
- Per-bus target samples the resolved `scl_i`/`sda_i` into one register stage (`scl_q`, `sda_q`) and detects edges against that stage.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high.
- START from any state, including a repeated START, goes to ADDR with the bit counter cleared. STOP from any state goes to IDLE.
- Data bits are sampled on SCL rising edges, MSB first.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, WAIT.
  - ADDR: after 8 bits, if `addr[7:1] == TargetAddrBase+i` and the target is enabled, go to ADDR_ACK. Otherwise go to WAIT, which releases SDA and waits for START/STOP.
  - ADDR_ACK: pull SDA for the 9th clock. Then go to PTR if R/W=0, or to RDATA if R/W=1.
  - PTR: the first written byte loads the pointer, taken modulo MemDepth. Then PTR_ACK, then WDATA.
  - WDATA: each byte is written to `mem[ptr]` and the pointer increments with wrap. Then WACK, which pulls SDA, then WDATA again.
  - RDATA: drive `mem[ptr]` bits; a 0 bit is driven as a pull, a 1 bit as release. After 8 bits, go to RACK with SDA released.
  - RACK: sample the controller ACK on the 9th SCL rise. ACK (SDA low) increments the pointer and returns to RDATA. NACK goes to WAIT.
- Reset values:
  - `mem[k] = k[7:0]`.
  - pointer 0, state IDLE.
  - `tgt_pull = 0`, so `scl_i`/`sda_i` follow the controller drive only.
  - `busy_o = 0`.
  - `scl_q`/`sda_q` = 1.

## Timing
- `scl_i`/`sda_i` have zero latency from the controller inputs and from the registered `tgt_pull`.
- Edge detection adds one cycle: an edge present on `scl_i` in cycle n is acted on in cycle n+1.
- Target SDA changes happen only in the cycle after a detected SCL falling edge. They are therefore stable before the next SCL rise, provided SCL low lasts at least 3 `clk_i` cycles.
- ACK pull begins after the falling edge that ends bit 8. It is released after the falling edge that ends bit 9.
- A START or STOP detected while `tgt_pull = 1` releases SDA in the same cycle the state changes.
- `busy_o` rises the cycle after START detection and falls the cycle after STOP detection.
- Simultaneous SCL and SDA edges are not START/STOP. They are treated as an SCL edge only.
- Reset mid-transfer: on the first cycle with `rst_i` sampled high, all registers, including memory, take their reset values. The SDA pull is released next edge.
- Pointer wraps from MemDepth-1 to 0. Pointer bytes ≥ MemDepth are masked to `$clog2(MemDepth)` bits.

## Test plan
- Bus 0 write: START, 0xA0, 0x03, 0xA5, 0x5A, STOP → `sda_i` low on all four 9th clocks; `mem[3]=A5`, `mem[4]=5A`; `busy_o` 1 then 0.
- Read: write pointer 0x03, repeated START, 0xA1, read 2 bytes with ACK then NACK → 0xA5, 0x5A returned; SDA released after NACK; state WAIT, then IDLE on STOP.
- Address miss: START, 0xA4 (addr 0x52, NumBus=2) → `sda_i` high on the 9th clock; no memory change; no pull until STOP.
- Wrap: MemDepth=16, pointer 0x1F (masks to 0x0F), write 0x11, 0x22 → `mem[15]=11`, `mem[0]=22`. A read from pointer 0x0E returns 0x0E, 0x11, 0x22.
- Reset mid-read while the target drives 0: assert `rst_i` one cycle → `sda_i` returns to 1 the next edge; `mem[3]` reads back 0x03.
- Multi-bus isolation: concurrent transfers on bus 0 (0x50) and bus 1 (0x51, 0xA2) → each bus ACKs only its own address. `scl_oe_i[1]=1`, `scl_o[1]=0` forces `scl_i[1]=0`, with `scl_i[0]` unaffected.
